// File: rtl/ex_mem_stage_pkg.sv
// ex_mem_stage_pkg: shared ALU op codes, FSM states and forward-select codes
package ex_mem_stage_pkg;
  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLT = 3'b101,
    ALU_NOR = 3'b110,
    ALU_MUL = 3'b111
  } alu_op_e;
  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_e;
  typedef enum logic [1:0] {FWD_REG, FWD_EXMEM, FWD_MEMWB} fwd_e;
endpackage

// File: rtl/ex_mem_stage_mul_seq.sv
// mul_seq: shift-add multiplier, one partial product per busy cycle, DATA_W iterations
module mul_seq #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              busy,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              done,
  output logic [DATA_W-1:0] product
);
  localparam int CW = $clog2(DATA_W);
  logic [DATA_W-1:0] mcand, mplier, acc;
  logic [CW-1:0] count;
  assign done = busy && count == CW'(DATA_W - 1);
  assign product = acc;
  // load operands on start, then accumulate and shift once per busy cycle
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      mcand <= '0;
      mplier <= '0;
      acc <= '0;
      count <= '0;
    end else if (start) begin
      mcand <= a;
      mplier <= b;
      acc <= '0;
      count <= '0;
    end else if (busy) begin
      acc <= mplier[0] ? acc + mcand : acc;
      mcand <= mcand << 1;
      mplier <= mplier >> 1;
      count <= done ? count : count + 1'b1;
    end
endmodule

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: execute stage with operand forwarding, ALU, sequential multiply and EX/MEM register
module ex_mem_stage
  import ex_mem_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reg_write_in,
  input  logic              mem_to_reg_in,
  input  logic              mem_write_in,
  input  logic              alu_src_in,
  input  logic [2:0]        alu_op_in,
  input  logic [DATA_W-1:0] rd1_in,
  input  logic [DATA_W-1:0] rd2_in,
  input  logic [DATA_W-1:0] sign_ext_in,
  input  logic [REG_AW-1:0] rs_in,
  input  logic [REG_AW-1:0] rt_in,
  input  logic [REG_AW-1:0] rd_in,
  input  logic              wb_reg_write,
  input  logic [REG_AW-1:0] wb_write_reg,
  input  logic [DATA_W-1:0] wb_result,
  output logic              reg_write_out,
  output logic              mem_to_reg_out,
  output logic              mem_write_out,
  output logic [DATA_W-1:0] alu_result_out,
  output logic [DATA_W-1:0] write_data_out,
  output logic [REG_AW-1:0] write_reg_out,
  output logic              stall_out
);
  fwd_e fwd_a, fwd_b;
  state_e state, state_nx;
  logic [DATA_W-1:0] op_a, rt_val, op_b, alu_y, product, l_wdata;
  logic [REG_AW-1:0] dest, l_wreg;
  logic is_mul, start, mul_done, l_rw, l_mtr, l_mw;
  assign is_mul = alu_op_in == ALU_MUL;
  assign dest = alu_src_in ? rt_in : rd_in;
  assign stall_out = reset && (state == ST_BUSY || (state == ST_IDLE && is_mul));
  // forward-source selection (EX/MEM over MEM/WB, r0 never forwarded) and operand muxes
  always_comb begin
    fwd_a = (reg_write_out && write_reg_out != '0 && write_reg_out == rs_in) ? FWD_EXMEM
          : (wb_reg_write && wb_write_reg != '0 && wb_write_reg == rs_in) ? FWD_MEMWB : FWD_REG;
    fwd_b = (reg_write_out && write_reg_out != '0 && write_reg_out == rt_in) ? FWD_EXMEM
          : (wb_reg_write && wb_write_reg != '0 && wb_write_reg == rt_in) ? FWD_MEMWB : FWD_REG;
    op_a = fwd_a == FWD_EXMEM ? alu_result_out : fwd_a == FWD_MEMWB ? wb_result : rd1_in;
    rt_val = fwd_b == FWD_EXMEM ? alu_result_out : fwd_b == FWD_MEMWB ? wb_result : rd2_in;
    op_b = alu_src_in ? sign_ext_in : rt_val;
  end
  // single-cycle ALU; MUL is handled by the sequential multiplier
  always_comb begin
    alu_y = '0;
    case (alu_op_in)
      ALU_ADD: alu_y = op_a + op_b;
      ALU_SUB: alu_y = op_a - op_b;
      ALU_AND: alu_y = op_a & op_b;
      ALU_OR:  alu_y = op_a | op_b;
      ALU_XOR: alu_y = op_a ^ op_b;
      ALU_SLT: alu_y = {{(DATA_W-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      ALU_NOR: alu_y = ~(op_a | op_b);
      default: alu_y = '0;
    endcase
  end
  // multiply sequencing: IDLE starts on MUL, BUSY iterates, DONE drains into EX/MEM
  always_comb begin
    state_nx = state;
    start = 1'b0;
    case (state)
      ST_IDLE: begin
        start = is_mul;
        state_nx = is_mul ? ST_BUSY : ST_IDLE;
      end
      ST_BUSY: state_nx = mul_done ? ST_DONE : ST_BUSY;
      default: state_nx = ST_IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= ST_IDLE;
    else state <= state_nx;
  // hold the multiply's controls and store data while ID/EX stays frozen
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      l_rw <= 1'b0;
      l_mtr <= 1'b0;
      l_mw <= 1'b0;
      l_wreg <= '0;
      l_wdata <= '0;
    end else if (start) begin
      l_rw <= reg_write_in;
      l_mtr <= mem_to_reg_in;
      l_mw <= mem_write_in;
      l_wreg <= dest;
      l_wdata <= rt_val;
    end
  // EX/MEM register: ALU result, finished product, or a bubble while multiplying
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      reg_write_out <= 1'b0;
      mem_to_reg_out <= 1'b0;
      mem_write_out <= 1'b0;
      alu_result_out <= '0;
      write_data_out <= '0;
      write_reg_out <= '0;
    end else if (state == ST_DONE) begin
      reg_write_out <= l_rw;
      mem_to_reg_out <= l_mtr;
      mem_write_out <= l_mw;
      alu_result_out <= product;
      write_data_out <= l_wdata;
      write_reg_out <= l_wreg;
    end else if (state == ST_IDLE && !is_mul) begin
      reg_write_out <= reg_write_in;
      mem_to_reg_out <= mem_to_reg_in;
      mem_write_out <= mem_write_in;
      alu_result_out <= alu_y;
      write_data_out <= rt_val;
      write_reg_out <= dest;
    end else begin
      reg_write_out <= 1'b0;
      mem_to_reg_out <= 1'b0;
      mem_write_out <= 1'b0;
      alu_result_out <= '0;
      write_data_out <= '0;
      write_reg_out <= '0;
    end
  mul_seq #(.DATA_W(DATA_W)) u_mul (
    .clk(clk),
    .reset(reset),
    .start(start),
    .busy(state == ST_BUSY),
    .a(op_a),
    .b(op_b),
    .done(mul_done),
    .product(product)
  );
endmodule

// File: tb/tb_ex_mem_stage.sv
// tb_ex_mem_stage: scoreboard bench for forwarding, ALU, multiply stall timing and reset
module tb_ex_mem_stage;
  logic clk = 1'b0, reset = 1'b0;
  logic reg_write_in, mem_to_reg_in, mem_write_in, alu_src_in, wb_reg_write;
  logic [2:0] alu_op_in;
  logic [31:0] rd1_in, rd2_in, sign_ext_in, wb_result;
  logic [4:0] rs_in, rt_in, rd_in, wb_write_reg;
  logic reg_write_out, mem_to_reg_out, mem_write_out, stall_out;
  logic [31:0] alu_result_out, write_data_out;
  logic [4:0] write_reg_out;
  int total = 0, bad = 0;

  typedef struct packed {
    logic [2:0] op; logic src; logic [4:0] rs, rt, rd;
    logic [31:0] a, b, imm; logic wbrw; logic [4:0] wbwr; logic [31:0] wbres;
    logic [1:0] ctl; logic [31:0] res, wd; logic [4:0] wr;
  } ins_t;
  typedef struct packed {logic [31:0] res, wd; logic [4:0] wr; logic [1:0] ctl;} exp_t;
  exp_t sb[$];

  ex_mem_stage dut (
    .clk(clk), .reset(reset),
    .reg_write_in(reg_write_in), .mem_to_reg_in(mem_to_reg_in), .mem_write_in(mem_write_in),
    .alu_src_in(alu_src_in), .alu_op_in(alu_op_in),
    .rd1_in(rd1_in), .rd2_in(rd2_in), .sign_ext_in(sign_ext_in),
    .rs_in(rs_in), .rt_in(rt_in), .rd_in(rd_in),
    .wb_reg_write(wb_reg_write), .wb_write_reg(wb_write_reg), .wb_result(wb_result),
    .reg_write_out(reg_write_out), .mem_to_reg_out(mem_to_reg_out), .mem_write_out(mem_write_out),
    .alu_result_out(alu_result_out), .write_data_out(write_data_out),
    .write_reg_out(write_reg_out), .stall_out(stall_out)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic ins_t mk(input logic [2:0] op, input logic src, input logic [4:0] rs, rt, rd,
                              input logic [31:0] a, b, imm, input logic wbrw, input logic [4:0] wbwr,
                              input logic [31:0] wbres, input logic [1:0] ctl,
                              input logic [31:0] res, wd, input logic [4:0] wr);
    ins_t i;
    i.op = op; i.src = src; i.rs = rs; i.rt = rt; i.rd = rd;
    i.a = a; i.b = b; i.imm = imm; i.wbrw = wbrw; i.wbwr = wbwr; i.wbres = wbres;
    i.ctl = ctl; i.res = res; i.wd = wd; i.wr = wr;
    return i;
  endfunction

  task automatic drive(input ins_t i);
    exp_t e;
    alu_op_in = i.op; alu_src_in = i.src; rs_in = i.rs; rt_in = i.rt; rd_in = i.rd;
    rd1_in = i.a; rd2_in = i.b; sign_ext_in = i.imm;
    wb_reg_write = i.wbrw; wb_write_reg = i.wbwr; wb_result = i.wbres;
    reg_write_in = 1'b1; {mem_to_reg_in, mem_write_in} = i.ctl;
    e.res = i.res; e.wd = i.wd; e.wr = i.wr; e.ctl = i.ctl;
    sb.push_back(e);
  endtask

  task automatic nop();
    alu_op_in = 3'd0; alu_src_in = 0; rs_in = 0; rt_in = 0; rd_in = 0;
    rd1_in = 0; rd2_in = 0; sign_ext_in = 0; wb_reg_write = 0; wb_write_reg = 0; wb_result = 0;
    reg_write_in = 0; mem_to_reg_in = 0; mem_write_in = 0;
  endtask

  task automatic pop(output exp_t e);
    e = sb.size() != 0 ? sb.pop_front() : 'x;
  endtask

  task automatic test_reset();
    nop();
    alu_op_in = 3'b111;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({reg_write_out, mem_to_reg_out, mem_write_out, alu_result_out, write_data_out, write_reg_out, stall_out} !== '0) begin
      bad++;
      $display("FAIL reset_hold: got rw=%b res=%h wd=%h wr=%0d stall=%b, want all 0", reg_write_out, alu_result_out, write_data_out, write_reg_out, stall_out);
    end
    nop();
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if ({reg_write_out, mem_to_reg_out, mem_write_out, alu_result_out, write_data_out, write_reg_out, stall_out} !== '0) begin
      bad++;
      $display("FAIL reset_release: got rw=%b res=%h wd=%h wr=%0d stall=%b, want all 0", reg_write_out, alu_result_out, write_data_out, write_reg_out, stall_out);
    end
  endtask

  task automatic test_add();
    exp_t e;
    drive(mk(3'd0, 0, 1, 2, 3, 5, 7, 0, 0, 0, 0, 2'b00, 12, 7, 3));
    #1;
    total++;
    if (stall_out !== 1'b0) begin bad++; $display("FAIL add_stall: got %b want 0", stall_out); end
    @(posedge clk);
    #1;
    pop(e);
    total++;
    if ({alu_result_out, write_data_out, write_reg_out, mem_to_reg_out, mem_write_out, reg_write_out} !== {e.res, e.wd, e.wr, e.ctl, 1'b1}) begin
      bad++;
      $display("FAIL add: got res=%h wd=%h wr=%0d rw=%b want res=%h wd=%h wr=%0d rw=1", alu_result_out, write_data_out, write_reg_out, reg_write_out, e.res, e.wd, e.wr);
    end
  endtask

  task automatic test_forward();
    ins_t t[6];
    exp_t e;
    t[0] = mk(3'd0, 0, 1, 2, 4, 32'h10, 0, 0, 0, 0, 0, 2'b00, 32'h10, 0, 4);
    t[1] = mk(3'd3, 1, 4, 5, 0, 0, 32'h33, 0, 1, 4, 32'h99, 2'b10, 32'h10, 32'h33, 5);
    t[2] = mk(3'd0, 1, 7, 4, 0, 0, 32'hAA, 1, 1, 7, 32'h99, 2'b01, 32'h9A, 32'hAA, 4);
    t[3] = mk(3'd0, 0, 1, 4, 6, 1, 0, 0, 1, 4, 32'h99, 2'b00, 32'h9B, 32'h9A, 6);
    t[4] = mk(3'd0, 1, 1, 0, 9, 32'h55, 32'h11, 0, 1, 0, 32'h77, 2'b00, 32'h55, 32'h11, 0);
    t[5] = mk(3'd3, 1, 0, 8, 0, 32'h21, 0, 0, 1, 0, 32'h77, 2'b00, 32'h21, 0, 8);
    for (int k = 0; k < 6; k++) begin
      drive(t[k]);
      @(posedge clk);
      #1;
      pop(e);
      total++;
      if ({alu_result_out, write_data_out, write_reg_out, mem_to_reg_out, mem_write_out, reg_write_out} !== {e.res, e.wd, e.wr, e.ctl, 1'b1}) begin
        bad++;
        $display("FAIL forward[%0d]: got res=%h wd=%h wr=%0d ctl=%b%b rw=%b want res=%h wd=%h wr=%0d ctl=%b rw=1", k, alu_result_out, write_data_out, write_reg_out, mem_to_reg_out, mem_write_out, reg_write_out, e.res, e.wd, e.wr, e.ctl);
      end
    end
  endtask

  task automatic test_alu_ops();
    ins_t t[9];
    exp_t e;
    t[0] = mk(3'd5, 1, 1, 9, 3, 32'hFFFFFFFF, 0, 1, 0, 0, 0, 2'b00, 1, 0, 9);
    t[1] = mk(3'd1, 0, 1, 2, 10, 5, 7, 0, 0, 0, 0, 2'b00, 32'hFFFFFFFE, 7, 10);
    t[2] = mk(3'd2, 0, 1, 2, 10, 32'hF0F0, 32'h0FF0, 0, 0, 0, 0, 2'b00, 32'h00F0, 32'h0FF0, 10);
    t[3] = mk(3'd3, 0, 1, 2, 10, 32'hF000, 32'h000F, 0, 0, 0, 0, 2'b00, 32'hF00F, 32'h000F, 10);
    t[4] = mk(3'd4, 0, 1, 2, 10, 32'hFF00, 32'h0FF0, 0, 0, 0, 0, 2'b00, 32'hF0F0, 32'h0FF0, 10);
    t[5] = mk(3'd6, 0, 1, 2, 10, 0, 0, 0, 0, 0, 0, 2'b00, 32'hFFFFFFFF, 0, 10);
    t[6] = mk(3'd5, 0, 1, 2, 10, 5, 7, 0, 0, 0, 0, 2'b00, 1, 7, 10);
    t[7] = mk(3'd5, 0, 1, 2, 10, 7, 32'hFFFFFFFF, 0, 0, 0, 0, 2'b00, 0, 32'hFFFFFFFF, 10);
    t[8] = mk(3'd0, 0, 1, 2, 10, 32'hFFFFFFFF, 2, 0, 0, 0, 0, 2'b00, 1, 2, 10);
    for (int k = 0; k < 9; k++) begin
      drive(t[k]);
      @(posedge clk);
      #1;
      pop(e);
      total++;
      if ({alu_result_out, write_data_out, write_reg_out, reg_write_out} !== {e.res, e.wd, e.wr, 1'b1}) begin
        bad++;
        $display("FAIL alu[%0d]: got res=%h wd=%h wr=%0d rw=%b want res=%h wd=%h wr=%0d rw=1", k, alu_result_out, write_data_out, write_reg_out, reg_write_out, e.res, e.wd, e.wr);
      end
    end
  endtask

  task automatic mul(input logic [31:0] a, b);
    logic [31:0] p;
    int n;
    exp_t e;
    p = a * b;
    drive(mk(3'd7, 0, 1, 2, 12, a, b, 0, 0, 0, 0, 2'b00, p, b, 12));
    #1;
    n = 0;
    while (stall_out === 1'b1 && n < 60) begin
      n++;
      @(posedge clk);
      #1;
      total++;
      if ({reg_write_out, mem_to_reg_out, mem_write_out, alu_result_out, write_data_out, write_reg_out} !== '0) begin
        bad++;
        $display("FAIL mul_bubble: cycle %0d got rw=%b res=%h wd=%h wr=%0d want all 0", n, reg_write_out, alu_result_out, write_data_out, write_reg_out);
      end
      #1;
    end
    total++;
    if (n != 33) begin bad++; $display("FAIL mul_stall_len: got %0d cycles want 33", n); end
    @(posedge clk);
    #1;
    pop(e);
    total++;
    if ({alu_result_out, write_data_out, write_reg_out, reg_write_out} !== {e.res, e.wd, e.wr, 1'b1}) begin
      bad++;
      $display("FAIL mul %h*%h: got res=%h wd=%h wr=%0d rw=%b want res=%h wd=%h wr=%0d rw=1", a, b, alu_result_out, write_data_out, write_reg_out, reg_write_out, e.res, e.wd, e.wr);
    end
  endtask

  task automatic test_mul();
    mul(32'h00010003, 32'h5);
    nop();
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    mul(32'hFFFFFFFF, 32'hFFFFFFFF);
    mul(32'd3, 32'd4);
    nop();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_mul();
    drive(mk(3'd7, 0, 1, 2, 12, 7, 9, 0, 0, 0, 0, 2'b00, 63, 9, 12));
    void'(sb.pop_back());
    repeat (10) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    total++;
    if ({reg_write_out, mem_to_reg_out, mem_write_out, alu_result_out, write_data_out, write_reg_out, stall_out} !== '0) begin
      bad++;
      $display("FAIL mid_reset: got rw=%b res=%h wd=%h wr=%0d stall=%b want all 0", reg_write_out, alu_result_out, write_data_out, write_reg_out, stall_out);
    end
    nop();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    total++;
    if ({reg_write_out, alu_result_out, write_reg_out, stall_out} !== '0) begin
      bad++;
      $display("FAIL mid_reset_abandon: got rw=%b res=%h wr=%0d stall=%b want all 0", reg_write_out, alu_result_out, write_reg_out, stall_out);
    end
    mul(32'd7, 32'd9);
    nop();
    @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_add();
    test_forward();
    test_alu_ops();
    test_mul();
    test_back_to_back();
    test_reset_mid_mul();
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- Execute stage plus EX/MEM pipeline register. It consumes the ID/EX register outputs and contains the operand forwarding muxes, the ALU and an iterative 32-cycle shift-add multiplier.
- It registers the result, store data, destination register and the surviving control bits for the MEM stage.
- It raises stall_out while a multiply is in flight. This freezes PC, IF/ID and ID/EX.

Parameters:
- DATA_W, 32, datapath width; the multiplier iterates DATA_W times.
- REG_AW, 5, register-address width.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- reg_write_in, mem_to_reg_in, mem_write_in, alu_src_in  in  1 each  controls from ID/EX
- alu_op_in  in  3  ALU operation from ID/EX
- rd1_in, rd2_in, sign_ext_in  in  DATA_W each  operands and immediate from ID/EX
- rs_in, rt_in, rd_in  in  REG_AW each  register numbers from ID/EX
- wb_reg_write  in  1  MEM/WB write enable, used for forwarding
- wb_write_reg  in  REG_AW  MEM/WB destination register
- wb_result  in  DATA_W  MEM/WB writeback value
- reg_write_out, mem_to_reg_out, mem_write_out  out  1 each  registered controls to MEM
- alu_result_out  out  DATA_W  registered ALU or multiply result (memory address for load/store)
- write_data_out  out  DATA_W  registered forwarded rt value (store data)
- write_reg_out  out  REG_AW  registered destination: rt if alu_src_in=1, else rd
- stall_out  out  1  combinational hold request for PC, IF/ID and ID/EX

Behaviour:
- Reset (reset=0, asynchronous): every registered output is 0, the FSM goes to IDLE, the counter and multiplier registers are 0, and stall_out is 0.
- ALU op encoding:
  - 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR
  - 101 SLT (signed; result 1 or 0), 110 NOR
  - 111 MUL (low DATA_W bits of an unsigned product; equals the low bits of the signed product)
- Add, sub and multiply wrap modulo 2^DATA_W. There is no overflow flag.
- Forwarding applies to operand A (rs) and operand B (rt) independently:
  - First priority: EX/MEM, when reg_write_out=1, write_reg_out!=0 and it matches the register. The value is alu_result_out.
  - Second priority: MEM/WB, when wb_reg_write=1, wb_write_reg!=0 and it matches. The value is wb_result.
  - Otherwise: rd1_in or rd2_in.
- Register 0 is never forwarded.
- The ALU B input is sign_ext_in if alu_src_in=1, else forwarded rt. write_data_out always takes forwarded rt.
- Load-use hazards are the hazard unit's job; this block never stalls for them.
- Non-MUL ops have 1-cycle latency: results are registered on the next clk edge.
- FSM:
  - IDLE:
    - alu_op_in!=MUL: the EX/MEM register loads the ALU result and controls.
    - alu_op_in==MUL: stall_out=1 combinationally. The edge latches the forwarded A and B, controls and write_reg, sets counter=0 and moves to BUSY. EX/MEM loads a bubble (all outputs 0).
  - BUSY:
    - stall_out=1. Each cycle adds the shifted multiplicand when the current multiplier LSB is 1, then shifts.
    - EX/MEM loads a bubble every cycle.
    - When counter==DATA_W-1 the FSM moves to DONE; otherwise counter increments.
  - DONE:
    - stall_out=0; ID/EX inputs are ignored.
    - The edge loads the product, latched controls, write_reg and store data into EX/MEM, and the FSM returns to IDLE.
    - The same edge lets ID/EX advance, so the held MUL does not retrigger.
- MUL timing, with the MUL visible at the ID/EX outputs in cycle T:
  - stall_out is high in cycles T..T+DATA_W (33 cycles).
  - DONE occurs in cycle T+DATA_W+1.
  - The product appears on alu_result_out from cycle T+DATA_W+2.
- Back-to-back MULs: the second MUL is seen in IDLE on the cycle after DONE and starts normally.
- Forwarding during BUSY is irrelevant: the operands are already latched.
- Reset mid-multiply: the operation is abandoned and nothing is written to EX/MEM.

Decomposition:
- Shared package holds:
  - the ALU op codes (ALU_ADD .. ALU_MUL)
  - the FSM state encoding (ST_IDLE, ST_BUSY, ST_DONE)
  - the forward-select codes (FWD_REG, FWD_EXMEM, FWD_MEMWB)
- One sub-module, mul_seq: a shift-add multiplier with start, busy and done signals, product and counter.
- The forwarding logic, ALU, FSM and EX/MEM register stay in ex_mem_stage.

Test Plan:
- ADD without forwarding: rd1=5, rd2=7, alu_op=000, alu_src=0, rd=3, reg_write=1 -> next edge: alu_result_out=12, write_reg_out=3, reg_write_out=1, stall_out stays 0.
- Forward priority: the previous instruction writes r4=0x10 (now in EX/MEM), MEM/WB has r4=0x99, next op is OR with rs=4, rd1=0, rt immediate 0 -> alu_result_out=0x10. With rs=0 and EX/MEM write_reg=0 -> no forwarding.
- SLT signed: rd1=0xFFFFFFFF, sign_ext=1, alu_src=1, rt=9 -> alu_result_out=1, write_reg_out=9.
- MUL 0x00010003 x 0x00000005: stall_out is high for exactly 33 cycles and EX/MEM outputs are 0 throughout. Cycle T+34: alu_result_out=0x0005000F with reg_write_out=1.
- MUL wrap: 0xFFFFFFFF x 0xFFFFFFFF -> alu_result_out=0x00000001. Followed by back-to-back MUL 3x4 -> 12, each with full 33-cycle stall.
- Pull reset low in BUSY cycle 10 -> all outputs 0 and stall_out=0 immediately. After release, a fresh MUL completes with full latency and the correct product.
